// File: rtl/hws_fb_pkg.sv
// Shared defaults, request-source encoding and the buffer address helper
// for the framebuffer selector.
package hws_fb_pkg;

  localparam logic [31:0] FB_BASE_ADDR_DEF   = 32'h3800_0000;
  localparam logic [31:0] FB_FRAME_BYTES_DEF = 32'h0017_7000;
  localparam int          FB_DEB_TIMEOUT_DEF = 50000;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_SW,
    REQ_KEY,
    REQ_AUTO
  } req_src_e;

  // Start address of buffer idx; only ever evaluated on constant arguments.
  function automatic logic [31:0] fb_addr(input logic [31:0] base,
                                          input logic [31:0] stride,
                                          input logic [31:0] idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/hws_debounce.sv
// Two-flop synchroniser followed by a stability counter. chg_o strobes in
// the cycle a new value is accepted, with that value presented on nxt_o.
module hws_debounce #(
  parameter int               WIDTH     = 1,
  parameter int               TIMEOUT   = 4,
  parameter int               CW        = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             chg_o
);

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             differ;

  // Count while the synchronised input disagrees with the accepted value;
  // accept once it has held for TIMEOUT cycles.
  always_comb begin
    differ = (sync2_q != acc_q);
    chg_o  = differ && (cnt_q == CNT_LAST);
    nxt_o  = sync2_q;
    acc_d  = acc_q;
    cnt_d  = '0;
    if (chg_o) begin
      acc_d = sync2_q;
    end else if (differ) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser, accepted value and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
      acc_q   <= RESET_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/hws_fb_select.sv
// Framebuffer address selector: turns debounced switch / key / auto-cycle
// requests into a buffer index that only changes on a frame boundary.
module hws_fb_select
  import hws_fb_pkg::*;
#(
  parameter int          NB_BUF      = 4,
  parameter int          SW_W        = $clog2(NB_BUF),
  parameter logic [31:0] BASE_ADDR   = FB_BASE_ADDR_DEF,
  parameter logic [31:0] FRAME_BYTES = FB_FRAME_BYTES_DEF,
  parameter int          DEB_TIMEOUT = FB_DEB_TIMEOUT_DEF,
  parameter int          DEB_CW      = 16,
  parameter int          AUTO_PERIOD = 60
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic [SW_W-1:0] sel_sw,
  input  logic            key_next_n,
  input  logic            auto_en,
  input  logic            frame_start,
  output logic [31:0]     img_addr,
  output logic [SW_W-1:0] buf_idx,
  output logic            pending,
  output logic            swap_pulse
);

  localparam int              ACW       = $clog2(AUTO_PERIOD + 1);
  localparam logic [ACW-1:0]  AUTO_LAST = ACW'(AUTO_PERIOD - 1);
  localparam logic [SW_W-1:0] IDX_LAST  = SW_W'(NB_BUF - 1);

  logic [SW_W-1:0] sw_nxt;
  logic            sw_chg;
  logic            key_nxt;
  logic            key_chg;

  hws_debounce #(
    .WIDTH    (SW_W),
    .TIMEOUT  (DEB_TIMEOUT),
    .CW       (DEB_CW),
    .RESET_VAL('0)
  ) u_deb_sw (
    .clk_i (sys_clk),
    .rst_ni(sys_rst_n),
    .d_i   (sel_sw),
    .nxt_o (sw_nxt),
    .chg_o (sw_chg)
  );

  hws_debounce #(
    .WIDTH    (1),
    .TIMEOUT  (DEB_TIMEOUT),
    .CW       (DEB_CW),
    .RESET_VAL(1'b1)
  ) u_deb_key (
    .clk_i (sys_clk),
    .rst_ni(sys_rst_n),
    .d_i   (key_next_n),
    .nxt_o (key_nxt),
    .chg_o (key_chg)
  );

  // Constant table of buffer start addresses; no runtime multiply.
  logic [31:0] addr_rom [NB_BUF];
  for (genvar g = 0; g < NB_BUF; g++) begin : g_rom
    assign addr_rom[g] = fb_addr(BASE_ADDR, FRAME_BYTES, 32'(g));
  end

  logic [31:0]     img_addr_q, img_addr_d;
  logic [SW_W-1:0] buf_idx_q, buf_idx_d;
  logic [SW_W-1:0] target_q, target_d;
  logic            pending_q, pending_d;
  logic            swap_q, swap_d;
  logic [ACW-1:0]  auto_cnt_q, auto_cnt_d;

  req_src_e        req_src;
  logic [SW_W-1:0] req_val;
  logic [SW_W-1:0] base_idx;
  logic [SW_W-1:0] inc_idx;

  // Pick at most one request per cycle, switch over key over auto.
  always_comb begin
    base_idx = pending_q ? target_q : buf_idx_q;
    inc_idx  = (base_idx == IDX_LAST) ? '0 : base_idx + 1'b1;
    req_src  = REQ_NONE;
    req_val  = '0;
    if (sw_chg && (32'(sw_nxt) < 32'(NB_BUF))) begin
      req_src = REQ_SW;
      req_val = sw_nxt;
    end else if (key_chg && !key_nxt) begin
      req_src = REQ_KEY;
      req_val = inc_idx;
    end else if (auto_en && frame_start && (auto_cnt_q == AUTO_LAST)) begin
      req_src = REQ_AUTO;
      req_val = inc_idx;
    end
  end

  // Commit the held target on frame_start, then apply this cycle's request
  // against the post-commit state so it lands on the following frame.
  always_comb begin
    img_addr_d = img_addr_q;
    buf_idx_d  = buf_idx_q;
    target_d   = target_q;
    pending_d  = pending_q;
    swap_d     = 1'b0;
    auto_cnt_d = auto_cnt_q;

    if (frame_start && pending_q) begin
      buf_idx_d  = target_q;
      img_addr_d = addr_rom[target_q];
      pending_d  = 1'b0;
      swap_d     = 1'b1;
    end

    if (req_src != REQ_NONE) begin
      if (req_val != buf_idx_d) begin
        target_d  = req_val;
        pending_d = 1'b1;
      end else if (pending_d) begin
        pending_d = 1'b0;
      end
    end

    if (!auto_en || (req_src == REQ_SW) || (req_src == REQ_KEY)) begin
      auto_cnt_d = '0;
    end else if (frame_start) begin
      auto_cnt_d = (auto_cnt_q == AUTO_LAST) ? '0 : auto_cnt_q + 1'b1;
    end
  end

  // Selector state registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      img_addr_q <= BASE_ADDR;
      buf_idx_q  <= '0;
      target_q   <= '0;
      pending_q  <= 1'b0;
      swap_q     <= 1'b0;
      auto_cnt_q <= '0;
    end else begin
      img_addr_q <= img_addr_d;
      buf_idx_q  <= buf_idx_d;
      target_q   <= target_d;
      pending_q  <= pending_d;
      swap_q     <= swap_d;
      auto_cnt_q <= auto_cnt_d;
    end
  end

  assign img_addr   = img_addr_q;
  assign buf_idx    = buf_idx_q;
  assign pending    = pending_q;
  assign swap_pulse = swap_q;

endmodule

// File: tb/tb_hws_fb_select.sv
// Directed bench for hws_fb_select with NB_BUF=4, DEB_TIMEOUT=4, AUTO_PERIOD=3.
module tb_hws_fb_select;

  localparam int          NB_BUF = 4;
  localparam int          SW_W   = 2;
  localparam logic [31:0] A0     = 32'h3800_0000;
  localparam logic [31:0] A1     = 32'h3817_7000;
  localparam logic [31:0] A2     = 32'h382E_E000;
  localparam logic [31:0] A3     = 32'h3846_5000;

  logic            sys_clk = 1'b0;
  logic            sys_rst_n;
  logic [SW_W-1:0] sel_sw;
  logic            key_next_n;
  logic            auto_en;
  logic            frame_start;
  logic [31:0]     img_addr;
  logic [SW_W-1:0] buf_idx;
  logic            pending;
  logic            swap_pulse;

  int total = 0;
  int bad   = 0;

  hws_fb_select #(
    .NB_BUF     (NB_BUF),
    .SW_W       (SW_W),
    .BASE_ADDR  (32'h3800_0000),
    .FRAME_BYTES(32'h0017_7000),
    .DEB_TIMEOUT(4),
    .DEB_CW     (3),
    .AUTO_PERIOD(3)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .sel_sw     (sel_sw),
    .key_next_n (key_next_n),
    .auto_en    (auto_en),
    .frame_start(frame_start),
    .img_addr   (img_addr),
    .buf_idx    (buf_idx),
    .pending    (pending),
    .swap_pulse (swap_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  // Advance n active edges and settle 1 ns past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
  endtask

  task automatic press_key(input int lo, input int hi);
    key_next_n = 1'b0;
    cyc(lo);
    key_next_n = 1'b1;
    cyc(hi);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; sel_sw = '0; key_next_n = 1'b1; auto_en = 1'b0; frame_start = 1'b0;
    cyc(3);
    sys_rst_n = 1'b1;
    cyc(2);
    total++; if (img_addr !== A0) begin bad++; $display("FAIL rst_addr: got %h want %h", img_addr, A0); end
    total++; if (buf_idx !== 2'd0) begin bad++; $display("FAIL rst_idx: got %0d want 0", buf_idx); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL rst_pend: got %b want 0", pending); end
    total++; if (swap_pulse !== 1'b0) begin bad++; $display("FAIL rst_swap: got %b want 0", swap_pulse); end
  endtask

  task automatic test_switch_select();
    sel_sw = 2'd2;
    cyc(5);
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL sw_pend_early: got %b want 0", pending); end
    cyc(1);
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL sw_pend_6: got %b want 1", pending); end
    cyc(4);
    total++; if (img_addr !== A0) begin bad++; $display("FAIL sw_hold_addr: got %h want %h", img_addr, A0); end
    frame();
    total++; if (img_addr !== A2) begin bad++; $display("FAIL sw_commit_addr: got %h want %h", img_addr, A2); end
    total++; if (buf_idx !== 2'd2) begin bad++; $display("FAIL sw_commit_idx: got %0d want 2", buf_idx); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL sw_commit_pend: got %b want 0", pending); end
    total++; if (swap_pulse !== 1'b1) begin bad++; $display("FAIL sw_swap_hi: got %b want 1", swap_pulse); end
    cyc(1);
    total++; if (swap_pulse !== 1'b0) begin bad++; $display("FAIL sw_swap_lo: got %b want 0", swap_pulse); end
  endtask

  task automatic test_debounce();
    sel_sw = 2'd0;
    cyc(8);
    frame();
    total++; if (buf_idx !== 2'd0) begin bad++; $display("FAIL deb_back0: got %0d want 0", buf_idx); end
    cyc(1);
    press_key(3, 10);
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL deb_glitch: got %b want 0", pending); end
    key_next_n = 1'b0;
    cyc(8);
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL deb_press1: got %b want 1", pending); end
    key_next_n = 1'b1;
    cyc(8);
    press_key(8, 8);
    total++; if (buf_idx !== 2'd0) begin bad++; $display("FAIL deb_nocommit: got %0d want 0", buf_idx); end
    frame();
    total++; if (img_addr !== A2) begin bad++; $display("FAIL deb_two_press_addr: got %h want %h", img_addr, A2); end
    total++; if (buf_idx !== 2'd2) begin bad++; $display("FAIL deb_two_press_idx: got %0d want 2", buf_idx); end
    cyc(1);
  endtask

  task automatic test_wrap();
    sel_sw = 2'd3;
    cyc(8);
    frame();
    total++; if (img_addr !== A3) begin bad++; $display("FAIL wrap_at3_addr: got %h want %h", img_addr, A3); end
    cyc(1);
    press_key(8, 8);
    frame();
    total++; if (buf_idx !== 2'd0) begin bad++; $display("FAIL wrap_idx: got %0d want 0", buf_idx); end
    total++; if (img_addr !== A0) begin bad++; $display("FAIL wrap_addr: got %h want %h", img_addr, A0); end
    total++; if (swap_pulse !== 1'b1) begin bad++; $display("FAIL wrap_swap: got %b want 1", swap_pulse); end
    cyc(1);
  endtask

  task automatic test_auto();
    auto_en = 1'b1;
    cyc(2);
    frame(); cyc(5);
    frame(); cyc(5);
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL auto_before3: got %b want 0", pending); end
    frame();
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL auto_req3: got %b want 1", pending); end
    total++; if (swap_pulse !== 1'b0) begin bad++; $display("FAIL auto_noswap3: got %b want 0", swap_pulse); end
    cyc(5);
    frame();
    total++; if (img_addr !== A1) begin bad++; $display("FAIL auto_commit4: got %h want %h", img_addr, A1); end
    total++; if (swap_pulse !== 1'b1) begin bad++; $display("FAIL auto_swap4: got %b want 1", swap_pulse); end
    cyc(5);
    auto_en = 1'b0;
    cyc(2);
    auto_en = 1'b1;
    frame(); cyc(5);
    frame(); cyc(5);
    auto_en = 1'b0;
    cyc(2);
    frame();
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL auto_drop_pend: got %b want 0", pending); end
    cyc(5);
    frame();
    total++; if (buf_idx !== 2'd1 || swap_pulse !== 1'b0) begin
      bad++; $display("FAIL auto_drop_noswap: got idx=%0d swap=%b want idx=1 swap=0", buf_idx, swap_pulse);
    end
    cyc(2);
  endtask

  task automatic test_collisions();
    // Key acceptance lands on the same edge as frame_start.
    key_next_n = 1'b0;
    cyc(5);
    frame();
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL col_key_pend: got %b want 1", pending); end
    total++; if (swap_pulse !== 1'b0 || buf_idx !== 2'd1) begin
      bad++; $display("FAIL col_key_nocommit: got idx=%0d swap=%b want idx=1 swap=0", buf_idx, swap_pulse);
    end
    key_next_n = 1'b1;
    cyc(8);
    frame();
    total++; if (img_addr !== A2) begin bad++; $display("FAIL col_key_next_frame: got %h want %h", img_addr, A2); end
    cyc(1);
    sel_sw = 2'd0;
    cyc(8);
    frame();
    total++; if (buf_idx !== 2'd0) begin bad++; $display("FAIL col_back0: got %0d want 0", buf_idx); end
    cyc(1);
    // Switch to 3 and key press accepted together: switch wins over key (which would give 1).
    sel_sw = 2'd3;
    key_next_n = 1'b0;
    cyc(8);
    key_next_n = 1'b1;
    cyc(8);
    frame();
    total++; if (buf_idx !== 2'd3) begin bad++; $display("FAIL col_sw_wins_idx: got %0d want 3", buf_idx); end
    total++; if (img_addr !== A3) begin bad++; $display("FAIL col_sw_wins_addr: got %h want %h", img_addr, A3); end
    cyc(1);
  endtask

  task automatic test_reset_mid();
    key_next_n = 1'b0;
    cyc(8);
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL rmid_pend_set: got %b want 1", pending); end
    sys_rst_n = 1'b0;
    #1;
    total++; if (pending !== 1'b0 || buf_idx !== 2'd0 || img_addr !== A0) begin
      bad++; $display("FAIL rmid_async: got pend=%b idx=%0d addr=%h want 0 0 %h", pending, buf_idx, img_addr, A0);
    end
    cyc(2);
    sys_rst_n = 1'b1;
    cyc(1);
    frame();
    total++; if (swap_pulse !== 1'b0 || buf_idx !== 2'd0) begin
      bad++; $display("FAIL rmid_discard: got swap=%b idx=%0d want 0 0", swap_pulse, buf_idx);
    end
    key_next_n = 1'b1;
    cyc(4);
  endtask

  initial begin
    test_reset();
    test_switch_select();
    test_debounce();
    test_wrap();
    test_auto();
    test_collisions();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
